// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int KP_N = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } scan_state_t;

    // Lowest set bit as a one-hot code; zero in gives zero out.
    function automatic logic [KP_N-1:0] onehot_lowest(input logic [KP_N-1:0] v);
        logic [KP_N-1:0] res;
        res = '0;
        for (int i = KP_N - 1; i >= 0; i--) begin
            if (v[i]) begin
                res    = '0;
                res[i] = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, with a settable reset value.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, row debounce, one-hot key latch.
// Define KEYPAD_REPEAT_EN to re-pulse key_valid every REPEAT_CYCLES while a key is held.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_CYCLES   = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] r,
    output logic [3:0] c,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV + 1);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

    generate
        if (SCAN_DIV < 3 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
            $error("keypad_scanner: SCAN_DIV must be >= 3 and cycle counts >= 1");
        end
    endgenerate

    logic [KP_N-1:0] w_row_sync;
    logic [KP_N-1:0] w_row_s;
    logic            w_hit;

    scan_state_t     r_state, w_state_next;
    logic [DIV_W-1:0] r_div, w_div_next;
    logic [1:0]      r_cidx, w_cidx_next;
    logic [DB_W-1:0] r_cnt, w_cnt_next;
    logic [KP_N-1:0] r_cand_r, w_cand_r_next;
    logic [KP_N-1:0] r_cand_c, w_cand_c_next;
    logic [KP_N-1:0] r_r, w_r_next;
    logic [KP_N-1:0] r_c, w_c_next;
    logic            r_valid, w_valid_next;
    logic            r_held, w_held_next;
`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    logic [REP_W-1:0] r_rep, w_rep_next;
`endif

    // Rows idle high through the pull-ups, so the synchronizer resets to all ones.
    sync_2ff #(
        .WIDTH     (KP_N),
        .RESET_VAL ({KP_N{1'b1}})
    ) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row_n),
        .q     (w_row_sync)
    );

    assign w_row_s = ~w_row_sync;
    assign w_hit   = |(w_row_s & r_cand_r);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= SCAN;
            r_div    <= '0;
            r_cidx   <= '0;
            r_cnt    <= '0;
            r_cand_r <= '0;
            r_cand_c <= '0;
            r_r      <= '0;
            r_c      <= '0;
            r_valid  <= 1'b0;
            r_held   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_rep    <= '0;
`endif
        end else begin
            r_state  <= w_state_next;
            r_div    <= w_div_next;
            r_cidx   <= w_cidx_next;
            r_cnt    <= w_cnt_next;
            r_cand_r <= w_cand_r_next;
            r_cand_c <= w_cand_c_next;
            r_r      <= w_r_next;
            r_c      <= w_c_next;
            r_valid  <= w_valid_next;
            r_held   <= w_held_next;
`ifdef KEYPAD_REPEAT_EN
            r_rep    <= w_rep_next;
`endif
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_div_next    = r_div;
        w_cidx_next   = r_cidx;
        w_cnt_next    = r_cnt;
        w_cand_r_next = r_cand_r;
        w_cand_c_next = r_cand_c;
        w_r_next      = r_r;
        w_c_next      = r_c;
        w_valid_next  = 1'b0;
        w_held_next   = r_held;
`ifdef KEYPAD_REPEAT_EN
        w_rep_next    = r_rep;
`endif
        case (r_state)
            SCAN: begin
                // Rows are only trusted at the end of the column slot, after the synchronizer settles.
                if (r_div == DIV_W'(SCAN_DIV - 1)) begin
                    w_div_next = '0;
                    if (w_row_s == '0) begin
                        w_cidx_next = r_cidx + 2'd1;
                    end else begin
                        w_cand_r_next         = onehot_lowest(w_row_s);
                        w_cand_c_next         = '0;
                        w_cand_c_next[r_cidx] = 1'b1;
                        w_cnt_next            = '0;
                        w_state_next          = DEBOUNCE;
                    end
                end else begin
                    w_div_next = r_div + DIV_W'(1);
                end
            end
            DEBOUNCE: begin
                if (!w_hit) begin
                    w_cnt_next   = '0;
                    w_div_next   = '0;
                    w_cidx_next  = r_cidx + 2'd1;
                    w_state_next = SCAN;
                end else if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    w_cnt_next   = '0;
                    w_r_next     = r_cand_r;
                    w_c_next     = r_cand_c;
                    w_valid_next = 1'b1;
                    w_held_next  = 1'b1;
                    w_state_next = HELD;
`ifdef KEYPAD_REPEAT_EN
                    w_rep_next   = '0;
`endif
                end else begin
                    w_cnt_next = r_cnt + DB_W'(1);
                end
            end
            HELD: begin
                if (!w_hit) begin
                    w_cnt_next   = '0;
                    w_state_next = RELEASE;
                end
`ifdef KEYPAD_REPEAT_EN
                else if (r_rep == REP_W'(REPEAT_CYCLES - 1)) begin
                    w_rep_next   = '0;
                    w_valid_next = 1'b1;
                end else begin
                    w_rep_next = r_rep + REP_W'(1);
                end
`endif
            end
            RELEASE: begin
                // A bounce back to pressed resumes the hold without a new pulse.
                if (w_hit) begin
                    w_cnt_next   = '0;
                    w_state_next = HELD;
                end else if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    w_cnt_next   = '0;
                    w_div_next   = '0;
                    w_held_next  = 1'b0;
                    w_cidx_next  = r_cidx + 2'd1;
                    w_state_next = SCAN;
`ifdef KEYPAD_REPEAT_EN
                    w_rep_next   = '0;
`endif
                end else begin
                    w_cnt_next = r_cnt + DB_W'(1);
                end
            end
            default: begin
                w_state_next = SCAN;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < KP_N; gi++) begin : g_col
            assign col_n[gi] = (r_cidx != 2'(gi));
        end
    endgenerate

    assign r         = r_r;
    assign c         = r_c;
    assign key_valid = r_valid;
    assign key_held  = r_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a matrix keypad model drives the rows from col_n.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 8;
    localparam int RP = 20;
    localparam int MAX_LAT = 4 * SD + 2 + DB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] r;
    logic [3:0] c;
    logic       key_valid;
    logic       key_held;

    logic [3:0] pressed [4];
    logic [3:0] glitch_n = 4'hF;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] er;
        logic [3:0] ec;
        bit         is_rep;
        int         t0;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   last_pulse = 0;

    keypad_scanner #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_CYCLES   (RP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_n     (row_n),
        .col_n     (col_n),
        .r         (r),
        .c         (c),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Physical matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_n = glitch_n;
        for (int k = 0; k < 4; k++) begin
            if (!col_n[k]) row_n = row_n & ~pressed[k];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_held(input logic lvl, input int bound, input string name);
        int k;
        k = 0;
        while (key_held !== lvl && k < bound) begin
            step(1);
            k++;
        end
        chk(name, {31'd0, key_held}, {31'd0, lvl});
    endtask

    task automatic wait_col(input logic [3:0] want, input int bound, input string name);
        int k;
        k = 0;
        while (col_n !== want && k < bound) begin
            step(1);
            k++;
        end
        chk(name, {28'd0, col_n}, {28'd0, want});
    endtask

    // Reference: the accepted key is the lowest pressed row of the pressed column.
    task automatic press(input int col, input logic [3:0] rows);
        exp_t e;
        e.er = 4'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rows[i]) e.er = 4'd1 << i;
        end
        e.ec     = 4'd1 << col;
        e.is_rep = 1'b0;
        e.t0     = cyc;
        sb.push_back(e);
        pressed[col] = rows;
    endtask

    task automatic push_repeat(input logic [3:0] er, input logic [3:0] ec);
        exp_t e;
        e.er     = er;
        e.ec     = ec;
        e.is_rep = 1'b1;
        e.t0     = 0;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!reset && key_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_key_valid: pulse at cycle %0d r=%b c=%b, expected no pulse", cyc, r, c);
            end else begin
                mon_e = sb.pop_front();
                chk("key_r", {28'd0, r}, {28'd0, mon_e.er});
                chk("key_c", {28'd0, c}, {28'd0, mon_e.ec});
                if (mon_e.is_rep) begin
                    chk("repeat_gap", cyc - last_pulse, RP);
                end else begin
                    checks++;
                    if (cyc - mon_e.t0 < DB || cyc - mon_e.t0 > MAX_LAT) begin
                        errors++;
                        $display("FAIL press_latency: got %0d cycles, expected %0d..%0d", cyc - mon_e.t0, DB, MAX_LAT);
                    end
                end
            end
            last_pulse = cyc;
        end
    end

    initial begin
        logic [3:0] ecol;
        int         t_rise;
        int         rcol;
        logic [3:0] rrows;

        for (int k = 0; k < 4; k++) pressed[k] = 4'h0;

        // Reset state and idle column rotation
        step(3);
        chk("reset_col_n", {28'd0, col_n}, 32'hE);
        chk("reset_r", {28'd0, r}, 32'h0);
        chk("reset_c", {28'd0, c}, 32'h0);
        chk("reset_key_valid", {31'd0, key_valid}, 32'h0);
        chk("reset_key_held", {31'd0, key_held}, 32'h0);
        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            ecol = 4'hF;
            ecol[(k / SD) % 4] = 1'b0;
            chk("idle_col_n", {28'd0, col_n}, {28'd0, ecol});
            step(1);
        end
        chk("idle_r", {28'd0, r}, 32'h0);

        // Single key at row 1 / column 2
        press(2, 4'b0010);
        wait_held(1'b1, MAX_LAT + 4, "press_held_rise");
        chk("held_col_frozen", {28'd0, col_n}, 32'hB);
        step(5);
        chk("held_col_still", {28'd0, col_n}, 32'hB);
        chk("held_level", {31'd0, key_held}, 32'h1);
        pressed[2] = 4'h0;
        wait_held(1'b0, DB + 8, "release_held_fall");

        // Short glitch on row 0 during column 0
        wait_col(4'hD, 4 * SD + 2, "pre_glitch_leave_col0");
        wait_col(4'hE, 4 * SD + 2, "glitch_col0_start");
        glitch_n = 4'b1110;
        step(3);
        glitch_n = 4'hF;
        wait_col(4'hD, 2 * SD, "glitch_resume_col1");
        chk("glitch_no_hold", {31'd0, key_held}, 32'h0);
        step(2 * DB);

        // Press row 3 / column 0 then a bouncy release
        press(0, 4'b1000);
        wait_held(1'b1, MAX_LAT + 4, "bounce_held_rise");
        step(3);
        pressed[0] = 4'h0;
        step(3);
        pressed[0] = 4'b1000;
        step(2);
        chk("bounce_still_held", {31'd0, key_held}, 32'h1);
        pressed[0] = 4'h0;
        t_rise = cyc;
        wait_held(1'b0, DB + 8, "bounce_held_fall");
        checks++;
        if (cyc - t_rise < DB + 2 || cyc - t_rise > DB + 4) begin
            errors++;
            $display("FAIL release_delay: got %0d cycles, expected %0d..%0d", cyc - t_rise, DB + 2, DB + 4);
        end
        chk("bounce_resume_col1", {28'd0, col_n}, 32'hD);

        // Two rows in column 2, then a column-3 key while held
        press(2, 4'b0110);
        wait_held(1'b1, MAX_LAT + 4, "chord_held_rise");
        step(2);
        pressed[3] = 4'b0001;
        step(8);
        chk("chord_keep_r", {28'd0, r}, 32'h2);
        chk("chord_keep_c", {28'd0, c}, 32'h4);
        pressed[2] = 4'h0;
        pressed[3] = 4'h0;
        wait_held(1'b0, DB + 8, "chord_held_fall");

`ifdef KEYPAD_REPEAT_EN
        // Auto-repeat while held for 70 cycles after acceptance
        press(1, 4'b0100);
        push_repeat(4'b0100, 4'b0010);
        push_repeat(4'b0100, 4'b0010);
        push_repeat(4'b0100, 4'b0010);
        wait_held(1'b1, MAX_LAT + 4, "repeat_held_rise");
        step(69);
        pressed[1] = 4'h0;
        wait_held(1'b0, DB + 8, "repeat_held_fall");
        step(RP + 5);
`endif

        // Randomized single-column presses
        for (int n = 0; n < 12; n++) begin
            rcol  = int'($urandom_range(0, 3));
            rrows = 4'($urandom_range(1, 15));
            press(rcol, rrows);
            wait_held(1'b1, MAX_LAT + 4, "rand_held_rise");
            step(int'($urandom_range(0, 12)));
            pressed[rcol] = 4'h0;
            wait_held(1'b0, DB + 8, "rand_held_fall");
            step(int'($urandom_range(0, 10)));
        end

        // Reset while a key is held
        press(1, 4'b0001);
        wait_held(1'b1, MAX_LAT + 4, "midreset_held_rise");
        step(2);
        reset = 1'b1;
        pressed[1] = 4'h0;
        step(2);
        chk("midreset_col_n", {28'd0, col_n}, 32'hE);
        chk("midreset_r", {28'd0, r}, 32'h0);
        chk("midreset_c", {28'd0, c}, 32'h0);
        chk("midreset_key_held", {31'd0, key_held}, 32'h0);
        chk("midreset_key_valid", {31'd0, key_valid}, 32'h0);
        reset = 1'b0;
        step(4 * SD + 2 * DB);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
